riscv_pipe_ctrl: RTL and testbench

- Hazard and sequencing controller for the 5-stage RV32I pipeline.
- Drives stall, flush and bubble controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, and the EX-stage forwarding mux selects.
- Owns the data-memory request/acknowledge handshake with a wait-state FSM and a timeout error.
- Keeps a saturating stall-cycle performance counter.

---
 rtl/riscv_pipe_ctrl.sv | 153 +++++++++++++++
 tb/tb_riscv_pipe_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_pipe_ctrl.sv
// Hazard and sequencing controller for a 5-stage RV32I pipeline: forwarding selects,
// load-use / branch / memory-wait stall and flush controls, and a saturating stall counter.
module riscv_pipe_ctrl #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic [4:0]       i_id_rs1_addr,
    input  logic [4:0]       i_id_rs2_addr,
    input  logic             i_id_rs1_used,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_ex_rs1_addr,
    input  logic [4:0]       i_ex_rs2_addr,
    input  logic [4:0]       i_ex_rd_addr,
    input  logic             i_ex_ctrl_mem_read,
    input  logic             i_ex_branch_taken,
    input  logic [4:0]       i_mem_rd_addr,
    input  logic             i_mem_ctrl_reg_write,
    input  logic             i_mem_dmem_access,
    input  logic [4:0]       i_wb_rd_addr,
    input  logic             i_wb_ctrl_reg_write,
    input  logic             i_dmem_ack,
    output logic             o_dmem_req,
    output logic [1:0]       o_fwd_a_sel,
    output logic [1:0]       o_fwd_b_sel,
    output logic             o_pc_stall,
    output logic             o_ifid_stall,
    output logic             o_ifid_flush,
    output logic             o_idex_stall,
    output logic             o_idex_flush,
    output logic             o_exmem_stall,
    output logic             o_memwb_bubble,
    output logic             o_err,
    output logic [CNT_W-1:0] o_stall_cycles
);

    localparam int unsigned WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

    typedef enum logic [1:0] {StRun, StMemWait, StErr} state_t;

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait;
    logic              r_err;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_lu;
    logic w_br;
    logic w_frz;
    logic w_stall_cnt_en;

    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        // MEM wins over WB; x0 is never forwarded
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) return 2'd1;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs)) return 2'd2;
        return 2'd0;
    endfunction

    always_comb begin
        o_fwd_a_sel = fwd_sel(i_ex_rs1_addr, i_mem_ctrl_reg_write, i_mem_rd_addr,
                              i_wb_ctrl_reg_write, i_wb_rd_addr);
        o_fwd_b_sel = fwd_sel(i_ex_rs2_addr, i_mem_ctrl_reg_write, i_mem_rd_addr,
                              i_wb_ctrl_reg_write, i_wb_rd_addr);
    end

    always_comb begin
        w_lu = i_ex_ctrl_mem_read && (i_ex_rd_addr != 5'd0) &&
               ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
                (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));
        w_br = i_ex_branch_taken;

        w_frz      = 1'b0;
        o_dmem_req = 1'b0;
        unique case (r_state)
            StRun: begin
                w_frz      = i_mem_dmem_access && !i_dmem_ack;
                o_dmem_req = i_mem_dmem_access;
            end
            StMemWait: begin
                w_frz      = !i_dmem_ack;
                o_dmem_req = 1'b1;
            end
            StErr: begin
                w_frz      = 1'b1;
                o_dmem_req = 1'b0;
            end
            default: begin
                w_frz      = 1'b1;
                o_dmem_req = 1'b0;
            end
        endcase

        // Flushes are held off during a freeze so a taken branch is re-seen at release
        o_pc_stall     = w_frz || (w_lu && !w_br);
        o_ifid_stall   = w_frz || (w_lu && !w_br);
        o_ifid_flush   = w_br && !w_frz;
        o_idex_stall   = w_frz;
        o_idex_flush   = (w_br || w_lu) && !w_frz;
        o_exmem_stall  = w_frz;
        o_memwb_bubble = w_frz;
        w_stall_cnt_en = w_frz || (w_lu && !w_br);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state     <= StRun;
            r_wait      <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_stall_cnt_en && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            unique case (r_state)
                StRun: begin
                    if (i_mem_dmem_access && !i_dmem_ack) begin
                        r_state <= StMemWait;
                        r_wait  <= WAIT_W'(1);
                    end
                end
                StMemWait: begin
                    if (i_dmem_ack) begin
                        r_state <= StRun;
                        r_wait  <= '0;
                    end else if ((TIMEOUT != 0) && (r_wait == WAIT_MAX)) begin
                        r_state <= StErr;
                        r_err   <= 1'b1;
                    end else if (r_wait != {WAIT_W{1'b1}}) begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                StErr: begin
                    r_err <= 1'b1;
                end
                default: begin
                    r_state <= StErr;
                    r_err   <= 1'b1;
                end
            endcase
        end
    end

    assign o_err          = r_err;
    assign o_stall_cycles = r_stall_cnt;

endmodule

// File: tb/tb_riscv_pipe_ctrl.sv
// Self-checking bench for riscv_pipe_ctrl: vector table for the combinational hazard logic,
// hand sequences for memory wait, timeout, counter saturation and reset.
module tb_riscv_pipe_ctrl;

    localparam int unsigned TIMEOUT = 4;
    localparam int unsigned CNT_W   = 4;

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       id_u1;
        logic       id_u2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_load;
        logic       br;
        logic [4:0] mem_rd;
        logic       mem_rw;
        logic       mem_acc;
        logic [4:0] wb_rd;
        logic       wb_rw;
        logic       ack;
    } in_t;

    // ctl = {dmem_req, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
    //        exmem_stall, memwb_bubble}
    typedef struct packed {
        logic [1:0] fa;
        logic [1:0] fb;
        logic [7:0] ctl;
    } exp_t;

    typedef struct packed {
        in_t  i;
        exp_t e;
    } vec_t;

    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b0110_0100;
    localparam logic [7:0] C_BR   = 8'b0001_0100;
    localparam logic [7:0] C_REQ  = 8'b1000_0000;
    localparam logic [7:0] C_FRZR = 8'b1110_1011;
    localparam logic [7:0] C_FRZ  = 8'b0110_1011;
    localparam logic [7:0] C_REL  = 8'b1001_0100;

    logic clk = 1'b0;
    logic rstn;
    in_t  din;

    logic             dmem_req;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_stall;
    logic             idex_flush;
    logic             exmem_stall;
    logic             memwb_bubble;
    logic             err;
    logic [CNT_W-1:0] stall_cycles;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CNT_W-1:0] exp_cnt;
    exp_t exp_q[$];
    vec_t tab[15];

    always #5 clk = ~clk;

    riscv_pipe_ctrl #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (CNT_W)
    ) u_dut (
        .i_clk               (clk),
        .i_rstn              (rstn),
        .i_id_rs1_addr       (din.id_rs1),
        .i_id_rs2_addr       (din.id_rs2),
        .i_id_rs1_used       (din.id_u1),
        .i_id_rs2_used       (din.id_u2),
        .i_ex_rs1_addr       (din.ex_rs1),
        .i_ex_rs2_addr       (din.ex_rs2),
        .i_ex_rd_addr        (din.ex_rd),
        .i_ex_ctrl_mem_read  (din.ex_load),
        .i_ex_branch_taken   (din.br),
        .i_mem_rd_addr       (din.mem_rd),
        .i_mem_ctrl_reg_write(din.mem_rw),
        .i_mem_dmem_access   (din.mem_acc),
        .i_wb_rd_addr        (din.wb_rd),
        .i_wb_ctrl_reg_write (din.wb_rw),
        .i_dmem_ack          (din.ack),
        .o_dmem_req          (dmem_req),
        .o_fwd_a_sel         (fwd_a),
        .o_fwd_b_sel         (fwd_b),
        .o_pc_stall          (pc_stall),
        .o_ifid_stall        (ifid_stall),
        .o_ifid_flush        (ifid_flush),
        .o_idex_stall        (idex_stall),
        .o_idex_flush        (idex_flush),
        .o_exmem_stall       (exmem_stall),
        .o_memwb_bubble      (memwb_bubble),
        .o_err               (err),
        .o_stall_cycles      (stall_cycles)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic in_t fw(input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic [4:0] mrd, input logic mrw,
                               input logic [4:0] wrd, input logic wrw);
        in_t v = '0;
        v.ex_rs1 = rs1;
        v.ex_rs2 = rs2;
        v.mem_rd = mrd;
        v.mem_rw = mrw;
        v.wb_rd  = wrd;
        v.wb_rw  = wrw;
        return v;
    endfunction

    function automatic in_t hz(input logic ld, input logic [4:0] rd,
                               input logic [4:0] r1, input logic u1,
                               input logic [4:0] r2, input logic u2, input logic br);
        in_t v = '0;
        v.ex_load = ld;
        v.ex_rd   = rd;
        v.id_rs1  = r1;
        v.id_u1   = u1;
        v.id_rs2  = r2;
        v.id_u2   = u2;
        v.br      = br;
        return v;
    endfunction

    function automatic in_t mem(input logic acc, input logic ack, input logic br);
        in_t v = '0;
        v.mem_acc = acc;
        v.ack     = ack;
        v.br      = br;
        return v;
    endfunction

    // Drive one cycle, check combinational outputs mid-cycle, then registered state after the edge
    task automatic step(input string name, input in_t v, input exp_t e, input logic exp_err);
        exp_t got;
        din = v;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            chk({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = exp_q.pop_front();
            chk({name, "_fwd"}, {28'd0, fwd_a, fwd_b}, {28'd0, got.fa, got.fb});
            chk({name, "_ctl"},
                {24'd0, dmem_req, pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush,
                 exmem_stall, memwb_bubble},
                {24'd0, got.ctl});
            if (got.ctl[6] && (exp_cnt != {CNT_W{1'b1}})) exp_cnt = exp_cnt + 1'b1;
        end
        @(posedge clk);
        #1;
        chk({name, "_cnt"}, 32'(stall_cycles), 32'(exp_cnt));
        chk({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    endtask

    initial begin
        tab[0]  = '{i: '0,                              e: '{2'd0, 2'd0, C_NONE}};
        tab[1]  = '{i: fw(5'd5, 5'd0, 5'd5, 1, 5'd5, 1), e: '{2'd1, 2'd0, C_NONE}};
        tab[2]  = '{i: fw(5'd5, 5'd0, 5'd5, 0, 5'd5, 1), e: '{2'd2, 2'd0, C_NONE}};
        tab[3]  = '{i: fw(5'd0, 5'd0, 5'd0, 1, 5'd0, 1), e: '{2'd0, 2'd0, C_NONE}};
        tab[4]  = '{i: fw(5'd7, 5'd7, 5'd7, 1, 5'd7, 1), e: '{2'd1, 2'd1, C_NONE}};
        tab[5]  = '{i: fw(5'd0, 5'd9, 5'd9, 0, 5'd9, 1), e: '{2'd0, 2'd2, C_NONE}};
        tab[6]  = '{i: hz(1, 5'd3, 5'd0, 0, 5'd3, 1, 0), e: '{2'd0, 2'd0, C_LU}};
        tab[7]  = '{i: hz(1, 5'd3, 5'd0, 0, 5'd3, 1, 1), e: '{2'd0, 2'd0, C_BR}};
        tab[8]  = '{i: hz(1, 5'd3, 5'd0, 0, 5'd3, 0, 0), e: '{2'd0, 2'd0, C_NONE}};
        tab[9]  = '{i: hz(1, 5'd0, 5'd0, 1, 5'd0, 0, 0), e: '{2'd0, 2'd0, C_NONE}};
        tab[10] = '{i: hz(1, 5'd4, 5'd4, 1, 5'd0, 0, 0), e: '{2'd0, 2'd0, C_LU}};
        tab[11] = '{i: hz(0, 5'd4, 5'd4, 1, 5'd0, 0, 0), e: '{2'd0, 2'd0, C_NONE}};
        tab[12] = '{i: hz(0, 5'd0, 5'd0, 0, 5'd0, 0, 1), e: '{2'd0, 2'd0, C_BR}};
        tab[13] = '{i: mem(1, 1, 0),                    e: '{2'd0, 2'd0, C_REQ}};
        tab[14] = '{i: mem(0, 1, 0),                    e: '{2'd0, 2'd0, C_NONE}};

        din     = '0;
        rstn    = 1'b0;
        exp_cnt = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_cnt", 32'(stall_cycles), 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_req", {31'd0, dmem_req}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        for (int k = 0; k < 15; k++) begin
            step($sformatf("vec%0d", k), tab[k].i, tab[k].e, 1'b0);
        end

        // Three wait states, branch raised mid-freeze, flush only on release
        step("wait1", mem(1, 0, 0), '{2'd0, 2'd0, C_FRZR}, 1'b0);
        step("wait2", mem(1, 0, 1), '{2'd0, 2'd0, C_FRZR}, 1'b0);
        step("wait3", mem(1, 0, 1), '{2'd0, 2'd0, C_FRZR}, 1'b0);
        step("wait4", mem(1, 1, 1), '{2'd0, 2'd0, C_REL},  1'b0);
        step("wait_idle", mem(0, 0, 0), '{2'd0, 2'd0, C_NONE}, 1'b0);

        // Timeout: five frozen cycles, then ERR with the counter running into saturation
        for (int k = 1; k <= 5; k++) begin
            step($sformatf("to%0d", k), mem(1, 0, 0), '{2'd0, 2'd0, C_FRZR}, (k == 5));
        end
        for (int k = 0; k < 8; k++) begin
            step($sformatf("err%0d", k), mem(k[0], 1, 1), '{2'd0, 2'd0, C_FRZ}, 1'b1);
        end

        rstn = 1'b0;
        #1;
        exp_cnt = '0;
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_cnt", 32'(stall_cycles), 32'd0);
        chk("rst_stall", {31'd0, pc_stall}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Reset while waiting drops the request
        step("mw1", mem(1, 0, 0), '{2'd0, 2'd0, C_FRZR}, 1'b0);
        step("mw2", mem(1, 0, 0), '{2'd0, 2'd0, C_FRZR}, 1'b0);
        din = '0;
        #1;
        chk("mw_req_held", {31'd0, dmem_req}, 32'd1);
        rstn = 1'b0;
        #1;
        exp_cnt = '0;
        chk("mw_rst_req", {31'd0, dmem_req}, 32'd0);
        chk("mw_rst_frz", {31'd0, exmem_stall}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        step("post_rst", '0, '{2'd0, 2'd0, C_NONE}, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
